// File: rtl/m_trigger.sv
// ============================================================================
//  Module      : m_trigger
//  Description : ADC front end. Block-averages 2^DECIM raw samples and runs
//                an edge trigger (level, hysteresis, slope, holdoff) on the
//                averaged stream. POS is a one-cycle strobe aligned with
//                DVALID. Optional auto-trigger timeout is enabled by defining
//                the macro TRIG_AUTO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module m_trigger #(
  parameter int HOLDOFF = 4,
  parameter int TIMEOUT = 65535,
  parameter int TW      = 20
) (
  input  logic       CLK_ADC,
  input  logic       RST,
  input  logic [7:0] D,
  input  logic [7:0] LEVEL,
  input  logic [3:0] HYST,
  input  logic       SLOPE,
  input  logic [2:0] DECIM,
  input  logic       REARM,
  output logic [7:0] DOUT,
  output logic       DVALID,
  output logic       POS,
  output logic       ARMED,
  output logic       TIMED_OUT
);

  // Trigger FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_FIRED = 2'd3;

  localparam logic [7:0] C_HOLDOFF = 8'(HOLDOFF);

  // --------------------------------------------------------------------------
  // Decimator state
  // --------------------------------------------------------------------------
  logic [14:0] r_acc;     // running sum of the current group (max 128*255)
  logic [6:0]  r_cnt;     // index of the current sample within its group
  logic [2:0]  r_decim;   // group size exponent captured at group start
  logic [7:0]  r_dout;
  logic        r_dvalid;

  logic [2:0]  w_decim;
  logic [6:0]  w_mask;
  logic        w_last;
  logic [14:0] w_sum;
  logic [7:0]  w_s;

  // A new group uses the live DECIM; later samples use the captured value
  assign w_decim = (r_cnt == 7'd0) ? DECIM : r_decim;
  // N-1 for the active group size; the group ends when the index reaches it
  assign w_mask  = ~(7'h7f << w_decim);
  assign w_last  = (r_cnt == w_mask);
  assign w_sum   = r_acc + {7'd0, D};
  // Truncating average; this is also the value the trigger evaluates
  assign w_s     = 8'(w_sum >> w_decim);

  // Accumulate N samples, emit the average with a one-cycle strobe
  always_ff @(posedge CLK_ADC) begin
    if (RST) begin
      r_acc    <= 15'd0;
      r_cnt    <= 7'd0;
      r_decim  <= 3'd0;
      r_dout   <= 8'd0;
      r_dvalid <= 1'b0;
    end else begin
      if (r_cnt == 7'd0) begin
        r_decim <= DECIM;
      end
      if (w_last) begin
        r_acc    <= 15'd0;
        r_cnt    <= 7'd0;
        r_dout   <= w_s;
        r_dvalid <= 1'b1;
      end else begin
        r_acc    <= w_sum;
        r_cnt    <= r_cnt + 7'd1;
        r_dvalid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Thresholds: 9-bit intermediates saturate into the 8-bit sample range
  // --------------------------------------------------------------------------
  logic [8:0] w_lo9;
  logic [8:0] w_hi9;
  logic [7:0] w_lo;
  logic [7:0] w_hi;
  logic       w_arm;
  logic       w_fire;

  assign w_lo9  = {1'b0, LEVEL} - {5'd0, HYST};
  assign w_hi9  = {1'b0, LEVEL} + {5'd0, HYST};
  assign w_lo   = w_lo9[8] ? 8'd0   : w_lo9[7:0];
  assign w_hi   = w_hi9[8] ? 8'hff  : w_hi9[7:0];
  // Arming requires the signal to sit beyond the hysteresis band on the
  // opposite side of the level from the edge being looked for
  assign w_arm  = SLOPE ? (w_s >= w_hi)  : (w_s <= w_lo);
  assign w_fire = SLOPE ? (w_s <= LEVEL) : (w_s >= LEVEL);

  // --------------------------------------------------------------------------
  // Trigger FSM
  // --------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [7:0] r_hcnt;     // consecutive arm-condition samples seen in HOLD
  logic       r_pos;

`ifdef TRIG_AUTO_EN
  localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_tmo;   // samples spent in WAIT without a crossing
  logic          r_tout;
`else
  // Timeout sizing only matters when the auto-trigger is built in
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT > TW);
`endif

  // Sequence IDLE -> HOLD -> WAIT -> FIRED; REARM returns to HOLD at once
  always_ff @(posedge CLK_ADC) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_hcnt  <= 8'd0;
      r_pos   <= 1'b0;
`ifdef TRIG_AUTO_EN
      r_tmo   <= '0;
      r_tout  <= 1'b0;
`endif
    end else begin
      r_pos <= 1'b0;
      if (REARM && (r_state != S_IDLE)) begin
        // REARM outranks a coincident crossing: no strobe this cycle
        r_state <= S_HOLD;
        r_hcnt  <= 8'd0;
`ifdef TRIG_AUTO_EN
        r_tmo   <= '0;
`endif
      end else if (w_last) begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_HOLD;
            r_hcnt  <= 8'd0;
          end
          S_HOLD: begin
            if (w_arm) begin
              if ((r_hcnt + 8'd1) == C_HOLDOFF) begin
                r_state <= S_WAIT;
                r_hcnt  <= 8'd0;
`ifdef TRIG_AUTO_EN
                r_tmo   <= '0;
`endif
              end else begin
                r_hcnt <= r_hcnt + 8'd1;
              end
            end else begin
              r_hcnt <= 8'd0;
            end
          end
          S_WAIT: begin
            if (w_fire) begin
              r_pos   <= 1'b1;
              r_state <= S_FIRED;
`ifdef TRIG_AUTO_EN
              r_tout  <= 1'b0;
`endif
            end
`ifdef TRIG_AUTO_EN
            else if (r_tmo == C_TMO_LAST) begin
              r_pos   <= 1'b1;
              r_tout  <= 1'b1;
              r_state <= S_FIRED;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
`endif
          end
          S_FIRED: begin
            // Parked until the next frame re-arms the trigger
            r_state <= S_FIRED;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign DOUT   = r_dout;
  assign DVALID = r_dvalid;
  assign POS    = r_pos;
  assign ARMED  = (r_state == S_WAIT);
`ifdef TRIG_AUTO_EN
  assign TIMED_OUT = r_tout;
`else
  assign TIMED_OUT = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_m_trigger.sv
// ============================================================================
//  Module      : tb_m_trigger
//  Description : Table-driven self-checking bench for m_trigger. Each table
//                record holds one cycle of stimulus and the outputs expected
//                one clock later; expectations go through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m_trigger;

`ifdef TRIG_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       CLK_ADC = 1'b0;
  logic       RST     = 1'b1;
  logic [7:0] D       = 8'd0;
  logic [7:0] LEVEL   = 8'd0;
  logic [3:0] HYST    = 4'd0;
  logic       SLOPE   = 1'b0;
  logic [2:0] DECIM   = 3'd0;
  logic       REARM   = 1'b0;
  logic [7:0] DOUT;
  logic       DVALID;
  logic       POS;
  logic       ARMED;
  logic       TIMED_OUT;

  always #5 CLK_ADC = ~CLK_ADC;

  m_trigger #(
    .HOLDOFF (4),
    .TIMEOUT (16),
    .TW      (20)
  ) dut (
    .CLK_ADC   (CLK_ADC),
    .RST       (RST),
    .D         (D),
    .LEVEL     (LEVEL),
    .HYST      (HYST),
    .SLOPE     (SLOPE),
    .DECIM     (DECIM),
    .REARM     (REARM),
    .DOUT      (DOUT),
    .DVALID    (DVALID),
    .POS       (POS),
    .ARMED     (ARMED),
    .TIMED_OUT (TIMED_OUT)
  );

  typedef struct {
    logic       rst;
    logic       rearm;
    logic [2:0] decim;
    logic [7:0] d;
    logic [7:0] lvl;
    logic [3:0] hy;
    logic       sl;
    logic [7:0] e_dout;
    logic       e_dv;
    logic       e_pos;
    logic       e_arm;
    logic       e_to;
    string      tag;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    logic       dv;
    logic       pos;
    logic       arm;
    logic       to;
    string      tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Trigger configuration applied to records added from here on
  logic [7:0] c_lvl = 8'd0;
  logic [3:0] c_hy  = 4'd0;
  logic       c_sl  = 1'b0;

  task automatic add(input logic rst, input logic rearm, input logic [2:0] decim,
                     input logic [7:0] d, input logic [7:0] edout, input logic edv,
                     input logic epos, input logic earm, input logic eto, input string tag);
    vec_t v;
    v.rst = rst; v.rearm = rearm; v.decim = decim; v.d = d;
    v.lvl = c_lvl; v.hy = c_hy; v.sl = c_sl;
    v.e_dout = edout; v.e_dv = edv; v.e_pos = epos; v.e_arm = earm; v.e_to = eto;
    v.tag = tag;
    tbl.push_back(v);
  endtask

  // DECIM=0 sample: every record produces DOUT = D with DVALID high
  task automatic add0(input logic rearm, input logic [7:0] d, input logic epos,
                      input logic earm, input logic eto, input string tag);
    add(1'b0, rearm, 3'd0, d, d, 1'b1, epos, earm, eto, tag);
  endtask

  task automatic check_head();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue, required one pending expectation");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if ({DOUT, DVALID, POS, ARMED, TIMED_OUT} !== {e.dout, e.dv, e.pos, e.arm, e.to}) begin
        n_bad++;
        $display("FAIL %s: got dout=%0d dv=%b pos=%b armed=%b to=%b, required dout=%0d dv=%b pos=%b armed=%b to=%b",
                 e.tag, DOUT, DVALID, POS, ARMED, TIMED_OUT, e.dout, e.dv, e.pos, e.arm, e.to);
      end
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    add(1'b1, 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    add(1'b1, 1'b0, 3'd0, 8'd77, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_hold");

    // ---------------- DECIM=0 ramp; arm condition s<=0 never recurs ----------------
    for (int i = 0; i < 256; i++) begin
      add0(1'b0, 8'(i), 1'b0, 1'b0, 1'b0, "ramp");
    end

    // ---------------- DECIM=2 block average ----------------
    for (int g = 0; g < 2; g++) begin
      add(1'b0, 1'b0, 3'd2, 8'd10, (g == 0) ? 8'd255 : 8'd25, 1'b0, 1'b0, 1'b0, 1'b0, "dec2_a");
      add(1'b0, 1'b0, 3'd2, 8'd20, (g == 0) ? 8'd255 : 8'd25, 1'b0, 1'b0, 1'b0, 1'b0, "dec2_b");
      add(1'b0, 1'b0, 3'd2, 8'd30, (g == 0) ? 8'd255 : 8'd25, 1'b0, 1'b0, 1'b0, 1'b0, "dec2_c");
      add(1'b0, 1'b0, 3'd2, 8'd40, 8'd25, 1'b1, 1'b0, 1'b0, 1'b0, "dec2_out");
    end
    // DECIM change mid-group only affects the next group
    add(1'b0, 1'b0, 3'd2, 8'd10, 8'd25, 1'b0, 1'b0, 1'b0, 1'b0, "decchg_a");
    add(1'b0, 1'b0, 3'd0, 8'd20, 8'd25, 1'b0, 1'b0, 1'b0, 1'b0, "decchg_b");
    add(1'b0, 1'b0, 3'd0, 8'd30, 8'd25, 1'b0, 1'b0, 1'b0, 1'b0, "decchg_c");
    add(1'b0, 1'b0, 3'd0, 8'd40, 8'd25, 1'b1, 1'b0, 1'b0, 1'b0, "decchg_out");
    add0(1'b0, 8'd77, 1'b0, 1'b0, 1'b0, "decchg_next");
    // DECIM=1 truncation: (3+4)>>1 = 3
    add(1'b0, 1'b0, 3'd1, 8'd3, 8'd77, 1'b0, 1'b0, 1'b0, 1'b0, "dec1_a");
    add(1'b0, 1'b0, 3'd1, 8'd4, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, "dec1_trunc");

    // ---------------- rising trigger, LEVEL=128 HYST=8 (lo=120) ----------------
    c_lvl = 8'd128; c_hy = 4'd8; c_sl = 1'b0;
    for (int k = 1; k <= 4; k++) add0(1'b0, 8'd100, 1'b0, (k == 4), 1'b0, "arm_rise");
    add0(1'b0, 8'd130, 1'b1, 1'b0, 1'b0, "fire_rise");
    add0(1'b0, 8'd130, 1'b0, 1'b0, 1'b0, "pos_single");
    for (int k = 0; k < 3; k++) add0(1'b0, 8'd100, 1'b0, 1'b0, 1'b0, "fired_park");
    // REARM then a REARM coincident with the crossing
    add0(1'b1, 8'd100, 1'b0, 1'b0, 1'b0, "rearm");
    for (int k = 1; k <= 4; k++) add0(1'b0, 8'd100, 1'b0, (k == 4), 1'b0, "rearm_arm");
    add0(1'b1, 8'd130, 1'b0, 1'b0, 1'b0, "rearm_wins");
    add0(1'b0, 8'd130, 1'b0, 1'b0, 1'b0, "rearm_hold");
    for (int k = 1; k <= 4; k++) add0(1'b0, 8'd100, 1'b0, (k == 4), 1'b0, "rearm_arm2");
    add0(1'b0, 8'd130, 1'b1, 1'b0, 1'b0, "fire_after_rearm");

    // ---------------- hysteresis band and exact boundaries ----------------
    add0(1'b1, 8'd125, 1'b0, 1'b0, 1'b0, "hyst_rearm");
    for (int k = 0; k < 8; k++) add0(1'b0, 8'd125, 1'b0, 1'b0, 1'b0, "hyst_band");
    for (int k = 1; k <= 4; k++) add0(1'b0, 8'd120, 1'b0, (k == 4), 1'b0, "arm_at_lo");
    add0(1'b0, 8'd127, 1'b0, 1'b1, 1'b0, "below_level");
    add0(1'b0, 8'd128, 1'b1, 1'b0, 1'b0, "fire_at_level");

    // ---------------- falling trigger, LEVEL=100 HYST=8 (hi=108) ----------------
    c_lvl = 8'd100; c_hy = 4'd8; c_sl = 1'b1;
    add0(1'b1, 8'd108, 1'b0, 1'b0, 1'b0, "fall_rearm");
    for (int k = 1; k <= 4; k++) add0(1'b0, 8'd108, 1'b0, (k == 4), 1'b0, "arm_fall");
    add0(1'b0, 8'd101, 1'b0, 1'b1, 1'b0, "fall_above");
    add0(1'b0, 8'd100, 1'b1, 1'b0, 1'b0, "fire_fall");

    // ---------------- saturation: LEVEL=250 HYST=15 -> hi clamps to 255 ----------------
    c_lvl = 8'd250; c_hy = 4'd15; c_sl = 1'b1;
    add0(1'b1, 8'd254, 1'b0, 1'b0, 1'b0, "sat_rearm");
    for (int k = 0; k < 4; k++) add0(1'b0, 8'd254, 1'b0, 1'b0, 1'b0, "sat_noarm");
    for (int k = 1; k <= 4; k++) add0(1'b0, 8'd255, 1'b0, (k == 4), 1'b0, "sat_arm");
    add0(1'b0, 8'd251, 1'b0, 1'b1, 1'b0, "sat_above");
    add0(1'b0, 8'd250, 1'b1, 1'b0, 1'b0, "sat_fire");

    // ---------------- auto-trigger after 16 samples in WAIT ----------------
    c_lvl = 8'd128; c_hy = 4'd8; c_sl = 1'b0;
    add0(1'b1, 8'd50, 1'b0, 1'b0, 1'b0, "auto_rearm");
    for (int k = 1; k <= 4; k++) add0(1'b0, 8'd50, 1'b0, (k == 4), 1'b0, "auto_arm");
    for (int k = 1; k <= 16; k++) begin
      if (k < 16) add0(1'b0, 8'd50, 1'b0, 1'b1, 1'b0, "auto_wait");
      else        add0(1'b0, 8'd50, AUTO, !AUTO, AUTO, "auto_fire");
    end
    for (int k = 0; k < 2; k++) add0(1'b0, 8'd50, 1'b0, !AUTO, AUTO, "auto_after");
    add0(1'b1, 8'd100, 1'b0, 1'b0, AUTO, "auto_rearm2");
    for (int k = 1; k <= 4; k++) add0(1'b0, 8'd100, 1'b0, (k == 4), AUTO, "auto_rearm_arm");
    add0(1'b0, 8'd130, 1'b1, 1'b0, 1'b0, "real_clears_to");

    // ---------------- reset in the middle of a group ----------------
    add(1'b0, 1'b0, 3'd2, 8'd200, 8'd130, 1'b0, 1'b0, 1'b0, 1'b0, "pre_rst_a");
    add(1'b0, 1'b0, 3'd2, 8'd200, 8'd130, 1'b0, 1'b0, 1'b0, 1'b0, "pre_rst_b");
    add(1'b1, 1'b0, 3'd2, 8'd200, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_mid");
    add(1'b0, 1'b0, 3'd2, 8'd4, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_a");
    add(1'b0, 1'b0, 3'd2, 8'd8, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_b");
    add(1'b0, 1'b0, 3'd2, 8'd12, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst_c");
    add(1'b0, 1'b0, 3'd2, 8'd16, 8'd10, 1'b1, 1'b0, 1'b0, 1'b0, "post_rst_avg");
    add0(1'b0, 8'd5, 1'b0, 1'b0, 1'b0, "post_rst_d0");

    // ---------------- apply the table ----------------
    for (int i = 0; i < tbl.size(); i++) begin
      exp_t e;
      @(negedge CLK_ADC);
      RST   = tbl[i].rst;
      REARM = tbl[i].rearm;
      DECIM = tbl[i].decim;
      D     = tbl[i].d;
      LEVEL = tbl[i].lvl;
      HYST  = tbl[i].hy;
      SLOPE = tbl[i].sl;
      e.dout = tbl[i].e_dout;
      e.dv   = tbl[i].e_dv;
      e.pos  = tbl[i].e_pos;
      e.arm  = tbl[i].e_arm;
      e.to   = tbl[i].e_to;
      e.tag  = tbl[i].tag;
      sb.push_back(e);
      @(posedge CLK_ADC);
      #1;
      check_head();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
